// File: rtl/rtn_xbar_rob_buffer_if.sv
// Bank-side write handshake and channel-side read/pop signals of the return-path reorder buffer.
// Flat vectors: bank b / channel c occupy slice [b*W +: W] / [c*W +: W].
interface rtn_xbar_rob_buffer_if #(
  parameter int NUM_BANKS = 4,
  parameter int NUM_CH    = 3,
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 128,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int PTR_W     = $clog2(DEPTH)
);
  logic [NUM_BANKS-1:0]           d_bank_rsp_valid;
  logic [NUM_BANKS-1:0]           d_bank_rsp_ready;
  logic [NUM_BANKS*DATA_W-1:0]    d_bank_rsp_data;
  logic [NUM_BANKS*CH_W-1:0]      d_bank_rsp_channel_id;
  logic [NUM_BANKS*PTR_W-1:0]     bank_w_ptr;
  logic [NUM_BANKS-1:0]           bank_w_vld;
  logic [NUM_CH*NUM_BANKS-1:0]    ch_bank_1hot_id;
  logic [NUM_CH*DEPTH-1:0]        ch_r_entry_1hot_id;
  logic [NUM_CH-1:0]              ch_rd_pop;
  logic [NUM_CH-1:0]              u_ch_bank_rsp_valid;
  logic [NUM_CH*DATA_W-1:0]       u_ch_bank_rsp_data;
  logic [NUM_BANKS*(PTR_W+1)-1:0] bank_free_cnt;

  modport slave (
    input  d_bank_rsp_valid, d_bank_rsp_data, d_bank_rsp_channel_id,
    input  ch_bank_1hot_id, ch_r_entry_1hot_id, ch_rd_pop,
    output d_bank_rsp_ready, bank_w_ptr, bank_w_vld,
    output u_ch_bank_rsp_valid, u_ch_bank_rsp_data, bank_free_cnt
  );

  modport master (
    output d_bank_rsp_valid, d_bank_rsp_data, d_bank_rsp_channel_id,
    output ch_bank_1hot_id, ch_r_entry_1hot_id, ch_rd_pop,
    input  d_bank_rsp_ready, bank_w_ptr, bank_w_vld,
    input  u_ch_bank_rsp_valid, u_ch_bank_rsp_data, bank_free_cnt
  );
endinterface

// File: rtl/rtn_xbar_rob_buffer.sv
// Return-path crossbar buffer: per-bank response stores drained out of order by channel-tagged reads.
// Optional macro RTN_XBAR_ERR_CHK_EN adds the err_sticky protocol-error output.
module rtn_xbar_rob_buffer #(
  parameter int NUM_BANKS = 4,
  parameter int NUM_CH    = 3,
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 128,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef RTN_XBAR_ERR_CHK_EN
  output logic [2:0]           err_sticky,
`endif
  rtn_xbar_rob_buffer_if.slave bus
);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [NUM_BANKS-1:0][DEPTH-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]               data_q [NUM_BANKS][DEPTH];
  logic [DATA_W-1:0]               data_d [NUM_BANKS][DEPTH];
  logic [CH_W-1:0]                 tag_q  [NUM_BANKS][DEPTH];
  logic [CH_W-1:0]                 tag_d  [NUM_BANKS][DEPTH];
  logic [NUM_BANKS-1:0][CNT_W-1:0] free_cnt_q, free_cnt_d;

  logic [NUM_BANKS-1:0][DATA_W-1:0] din;
  logic [NUM_BANKS-1:0][CH_W-1:0]   chid;
  logic [NUM_BANKS-1:0]             ready;
  logic [NUM_BANKS-1:0]             wr_en;
  logic [NUM_BANKS-1:0][PTR_W-1:0]  wr_ptr;

  logic [NUM_CH-1:0][NUM_BANKS-1:0] bsel;
  logic [NUM_CH-1:0][DEPTH-1:0]     esel;
  logic [NUM_CH-1:0][BANK_W-1:0]    rd_bank;
  logic [NUM_CH-1:0][PTR_W-1:0]     rd_ent;
  logic [NUM_CH-1:0]                rd_vld;
  logic [NUM_CH-1:0]                pop_ok;
  logic [NUM_CH-1:0][DATA_W-1:0]    rd_data;

  assign din  = bus.d_bank_rsp_data;
  assign chid = bus.d_bank_rsp_channel_id;
  assign bsel = bus.ch_bank_1hot_id;
  assign esel = bus.ch_r_entry_1hot_id;

  // Allocation looks only at registered valid bits, so a slot popped this cycle is reused next cycle.
  always_comb begin
    ready  = '0;
    wr_en  = '0;
    wr_ptr = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      ready[b] = |(~vld_q[b]);
      wr_en[b] = bus.d_bank_rsp_valid[b] & ready[b];
      if (wr_en[b]) begin
        for (int e = DEPTH - 1; e >= 0; e--) begin
          if (!vld_q[b][e]) wr_ptr[b] = PTR_W'(e);
        end
      end
    end
  end

  always_comb begin
    rd_bank = '0;
    rd_ent  = '0;
    rd_vld  = '0;
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = NUM_BANKS - 1; b >= 0; b--) begin
        if (bsel[c][b]) rd_bank[c] = BANK_W'(b);
      end
      for (int e = DEPTH - 1; e >= 0; e--) begin
        if (esel[c][e]) rd_ent[c] = PTR_W'(e);
      end
      rd_vld[c] = (|bsel[c]) & (|esel[c]) & vld_q[rd_bank[c]][rd_ent[c]] &
                  (tag_q[rd_bank[c]][rd_ent[c]] == CH_W'(c));
      if (rd_vld[c]) rd_data[c] = data_q[rd_bank[c]][rd_ent[c]];
    end
  end

  assign pop_ok = bus.ch_rd_pop & rd_vld;

  // Tag matching guarantees each entry is popped by at most one channel per cycle.
  always_comb begin
    vld_d      = vld_q;
    data_d     = data_q;
    tag_d      = tag_q;
    free_cnt_d = free_cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pop_ok[c]) vld_d[rd_bank[c]][rd_ent[c]] = 1'b0;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_en[b]) begin
        vld_d[b][wr_ptr[b]]  = 1'b1;
        data_d[b][wr_ptr[b]] = din[b];
        tag_d[b][wr_ptr[b]]  = chid[b];
        free_cnt_d[b]        = free_cnt_d[b] - CNT_W'(1);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (pop_ok[c] && (rd_bank[c] == BANK_W'(b))) free_cnt_d[b] = free_cnt_d[b] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      free_cnt_q <= {NUM_BANKS{CNT_W'(DEPTH)}};
    end else begin
      vld_q      <= vld_d;
      free_cnt_q <= free_cnt_d;
    end
  end

  // Payload storage is qualified by the valid bits and needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  assign bus.d_bank_rsp_ready    = ready;
  assign bus.bank_w_vld          = wr_en;
  assign bus.bank_w_ptr          = wr_ptr;
  assign bus.u_ch_bank_rsp_valid = rd_vld;
  assign bus.u_ch_bank_rsp_data  = rd_data;
  assign bus.bank_free_cnt       = free_cnt_q;

`ifdef RTN_XBAR_ERR_CHK_EN
  logic [2:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.ch_rd_pop[c]) begin
        if (!rd_vld[c]) err_d[0] = 1'b1;
        if (!$onehot(bsel[c]) || !$onehot(esel[c])) err_d[1] = 1'b1;
      end
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_en[b] && (int'(chid[b]) >= NUM_CH)) err_d[2] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_sticky = err_q;
`endif
endmodule

// File: tb/tb_rtn_xbar_rob_buffer.sv
// Randomized plus directed bench for rtn_xbar_rob_buffer against an entry-array reference model.
// Build with RTN_XBAR_ERR_CHK_EN defined to also check err_sticky.
module tb_rtn_xbar_rob_buffer;
  localparam int NB = 4;
  localparam int NC = 3;
  localparam int DP = 8;
  localparam int DW = 128;
  localparam int CW = 2;
  localparam int PW = 3;

  logic clk;
  logic rst;
`ifdef RTN_XBAR_ERR_CHK_EN
  logic [2:0] err_sticky;
`endif

  rtn_xbar_rob_buffer_if #(.NUM_BANKS(NB), .NUM_CH(NC), .DEPTH(DP), .DATA_W(DW), .CH_W(CW), .PTR_W(PW)) bus ();

  rtn_xbar_rob_buffer #(.NUM_BANKS(NB), .NUM_CH(NC), .DEPTH(DP), .DATA_W(DW), .CH_W(CW), .PTR_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef RTN_XBAR_ERR_CHK_EN
    .err_sticky (err_sticky),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus
  logic [NB-1:0] in_valid;
  logic [DW-1:0] in_data [NB];
  logic [CW-1:0] in_chid [NB];
  logic [NB-1:0] in_bsel [NC];
  logic [DP-1:0] in_esel [NC];
  logic [NC-1:0] in_pop;

  // reference model: contents of every bank entry
  bit            m_vld  [NB][DP];
  logic [DW-1:0] m_data [NB][DP];
  int            m_tag  [NB][DP];
  logic [2:0]    m_err;
  bit            armed;

  bit            e_ready [NB];
  bit            e_wvld  [NB];
  int            e_wptr  [NB];
  int            e_free  [NB];
  bit            e_uvalid[NC];
  logic [DW-1:0] e_udata [NC];
  int            e_sb    [NC];
  int            e_se    [NC];

  logic [NB-1:0] s_ready, s_wvld;
  int            s_wptr [NB];
  int            s_free [NB];
  logic [NC-1:0] s_uvalid;
  logic [DW-1:0] s_udata [NC];
  logic [2:0]    s_err;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hA5A5_0000 + 32'(i);
    return {w, ~w, w ^ 32'h0F0F_0F0F, 32'(i)};
  endfunction

  task automatic idle();
    in_valid = '0;
    in_pop   = '0;
    for (int b = 0; b < NB; b++) begin
      in_data[b] = '0;
      in_chid[b] = '0;
    end
    for (int c = 0; c < NC; c++) begin
      in_bsel[c] = '0;
      in_esel[c] = '0;
    end
  endtask

  task automatic apply();
    bus.d_bank_rsp_valid = in_valid;
    bus.ch_rd_pop        = in_pop;
    for (int b = 0; b < NB; b++) begin
      bus.d_bank_rsp_data[b*DW +: DW]       = in_data[b];
      bus.d_bank_rsp_channel_id[b*CW +: CW] = in_chid[b];
    end
    for (int c = 0; c < NC; c++) begin
      bus.ch_bank_1hot_id[c*NB +: NB]    = in_bsel[c];
      bus.ch_r_entry_1hot_id[c*DP +: DP] = in_esel[c];
    end
  endtask

  function automatic int low_bank(input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int low_ent(input logic [DP-1:0] v);
    for (int i = 0; i < DP; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic compute_exp();
    for (int b = 0; b < NB; b++) begin
      int nfree;
      int first;
      nfree = 0;
      first = -1;
      for (int e = 0; e < DP; e++) begin
        if (!m_vld[b][e]) begin
          nfree++;
          if (first < 0) first = e;
        end
      end
      e_free[b]  = nfree;
      e_ready[b] = (nfree > 0);
      e_wvld[b]  = in_valid[b] && e_ready[b];
      e_wptr[b]  = e_wvld[b] ? first : 0;
    end
    for (int c = 0; c < NC; c++) begin
      e_sb[c]     = low_bank(in_bsel[c]);
      e_se[c]     = low_ent(in_esel[c]);
      e_uvalid[c] = 1'b0;
      e_udata[c]  = '0;
      if (e_sb[c] >= 0 && e_se[c] >= 0) begin
        if (m_vld[e_sb[c]][e_se[c]] && m_tag[e_sb[c]][e_se[c]] == c) begin
          e_uvalid[c] = 1'b1;
          e_udata[c]  = m_data[e_sb[c]][e_se[c]];
        end
      end
    end
  endtask

  task automatic snapshot();
    s_ready  = bus.d_bank_rsp_ready;
    s_wvld   = bus.bank_w_vld;
    s_uvalid = bus.u_ch_bank_rsp_valid;
    for (int b = 0; b < NB; b++) begin
      s_wptr[b] = int'(bus.bank_w_ptr[b*PW +: PW]);
      s_free[b] = int'(bus.bank_free_cnt[b*(PW+1) +: PW+1]);
    end
    for (int c = 0; c < NC; c++) s_udata[c] = bus.u_ch_bank_rsp_data[c*DW +: DW];
`ifdef RTN_XBAR_ERR_CHK_EN
    s_err = err_sticky;
`else
    s_err = '0;
`endif
  endtask

  task automatic compare();
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("ready[%0d]", b), DW'(s_ready[b]), DW'(e_ready[b]));
      chk($sformatf("w_vld[%0d]", b), DW'(s_wvld[b]), DW'(e_wvld[b]));
      chk($sformatf("w_ptr[%0d]", b), DW'(s_wptr[b]), DW'(e_wptr[b]));
      chk($sformatf("free_cnt[%0d]", b), DW'(s_free[b]), DW'(e_free[b]));
    end
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("u_valid[%0d]", c), DW'(s_uvalid[c]), DW'(e_uvalid[c]));
      chk($sformatf("u_data[%0d]", c), s_udata[c], e_udata[c]);
    end
`ifdef RTN_XBAR_ERR_CHK_EN
    chk("err_sticky", DW'(s_err), DW'(m_err));
`endif
  endtask

  task automatic update_model();
    if (rst) begin
      for (int b = 0; b < NB; b++)
        for (int e = 0; e < DP; e++) m_vld[b][e] = 1'b0;
      m_err = '0;
      armed = 1'b1;
      return;
    end
    for (int c = 0; c < NC; c++) begin
      if (in_pop[c]) begin
        if (!e_uvalid[c]) m_err[0] = 1'b1;
        if (!$onehot(in_bsel[c]) || !$onehot(in_esel[c])) m_err[1] = 1'b1;
        if (e_uvalid[c]) m_vld[e_sb[c]][e_se[c]] = 1'b0;
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (e_wvld[b]) begin
        m_vld[b][e_wptr[b]]  = 1'b1;
        m_data[b][e_wptr[b]] = in_data[b];
        m_tag[b][e_wptr[b]]  = int'(in_chid[b]);
        if (int'(in_chid[b]) >= NC) m_err[2] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    apply();
    @(negedge clk);
    compute_exp();
    snapshot();
    if (armed) compare();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic pick_sel(input int c);
    int r, b, e;
    r = $urandom_range(0, 9);
    if (r == 0) begin
      in_bsel[c] = '0;
      in_esel[c] = '0;
    end else if (r == 1) begin
      in_bsel[c] = NB'($urandom);
      in_esel[c] = DP'($urandom);
    end else begin
      b = $urandom_range(0, NB - 1);
      e = $urandom_range(0, DP - 1);
      if (r >= 5) begin
        for (int k = 0; k < NB * DP; k++) begin
          int bb, ee;
          bb = (b + k / DP) % NB;
          ee = (e + k) % DP;
          if (m_vld[bb][ee] && m_tag[bb][ee] == c) begin
            b = bb;
            e = ee;
            break;
          end
        end
      end
      in_bsel[c] = NB'(1) << b;
      in_esel[c] = DP'(1) << e;
    end
  endtask

  initial begin
    armed = 1'b0;
    m_err = '0;
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    // reset state
    cycle();
    for (int b = 0; b < NB; b++) begin
      chk("rst_free", DW'(s_free[b]), DW'(DP));
      chk("rst_ready", DW'(s_ready[b]), DW'(1));
    end
    chk("rst_uvalid", DW'(s_uvalid), '0);
    for (int c = 0; c < NC; c++) chk("rst_udata", s_udata[c], '0);

    // fill bank 0
    for (int i = 0; i < DP; i++) begin
      idle();
      in_valid[0] = 1'b1;
      in_data[0]  = pat(i);
      in_chid[0]  = 2'd1;
      cycle();
      chk("fill_ptr", DW'(s_wptr[0]), DW'(i));
      chk("fill_wvld", DW'(s_wvld[0]), DW'(1));
    end
    cycle();
    chk("full_ready", DW'(s_ready[0]), DW'(0));
    chk("full_wvld", DW'(s_wvld[0]), DW'(0));
    chk("full_free", DW'(s_free[0]), DW'(0));

    // out-of-order drain of entry 5
    idle();
    in_bsel[1] = 4'b0001;
    in_esel[1] = 8'b0010_0000;
    in_pop[1]  = 1'b1;
    cycle();
    chk("ooo_valid", DW'(s_uvalid[1]), DW'(1));
    chk("ooo_data", s_udata[1], pat(5));
    idle();
    in_valid[0] = 1'b1;
    in_data[0]  = pat(8);
    in_chid[0]  = 2'd1;
    cycle();
    chk("ooo_ready", DW'(s_ready[0]), DW'(1));
    chk("ooo_ptr", DW'(s_wptr[0]), DW'(5));

    // tag isolation, no same-cycle bypass
    idle();
    in_valid[1] = 1'b1;
    in_data[1]  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    in_chid[1]  = 2'd2;
    in_bsel[2]  = 4'b0010;
    in_esel[2]  = 8'b0000_0001;
    cycle();
    chk("nobypass_valid", DW'(s_uvalid[2]), DW'(0));
    idle();
    in_bsel[0] = 4'b0010;
    in_esel[0] = 8'b0000_0001;
    in_bsel[2] = 4'b0010;
    in_esel[2] = 8'b0000_0001;
    cycle();
    chk("tag_ch0_valid", DW'(s_uvalid[0]), DW'(0));
    chk("tag_ch0_data", s_udata[0], '0);
    chk("tag_ch2_valid", DW'(s_uvalid[2]), DW'(1));
    chk("tag_ch2_data", s_udata[2], 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

    // full bank 3: pop and blocked write in one cycle, write lands next cycle
    for (int i = 0; i < DP; i++) begin
      idle();
      in_valid[3] = 1'b1;
      in_data[3]  = pat(16 + i);
      in_chid[3]  = 2'd0;
      cycle();
    end
    idle();
    in_valid[3] = 1'b1;
    in_data[3]  = pat(99);
    in_bsel[0]  = 4'b1000;
    in_esel[0]  = 8'b0000_0100;
    in_pop[0]   = 1'b1;
    cycle();
    chk("sim_ready", DW'(s_ready[3]), DW'(0));
    chk("sim_wvld", DW'(s_wvld[3]), DW'(0));
    chk("sim_free0", DW'(s_free[3]), DW'(0));
    chk("sim_pop_data", s_udata[0], pat(18));
    idle();
    in_valid[3] = 1'b1;
    in_data[3]  = pat(99);
    cycle();
    chk("sim_ready2", DW'(s_ready[3]), DW'(1));
    chk("sim_ptr", DW'(s_wptr[3]), DW'(2));
    chk("sim_free1", DW'(s_free[3]), DW'(1));
    idle();
    cycle();
    chk("sim_free2", DW'(s_free[3]), DW'(0));

    // reset mid-traffic with writes and pops in the reset cycle
    idle();
    in_valid   = '1;
    in_bsel[1] = 4'b0001;
    in_esel[1] = 8'b0000_0001;
    in_pop[1]  = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle();
    in_bsel[1] = 4'b0001;
    in_esel[1] = 8'b0000_0001;
    cycle();
    chk("mid_rst_valid", DW'(s_uvalid), '0);
    for (int b = 0; b < NB; b++) chk("mid_rst_free", DW'(s_free[b]), DW'(DP));
    idle();
    in_valid = '1;
    cycle();
    for (int b = 0; b < NB; b++) chk("mid_rst_ptr", DW'(s_wptr[b]), DW'(0));

`ifdef RTN_XBAR_ERR_CHK_EN
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    in_bsel[0] = 4'b0001;
    in_esel[0] = 8'b0000_0001;
    in_pop[0]  = 1'b1;
    cycle();
    idle();
    cycle();
    chk("err_pop_empty", DW'(s_err), DW'(3'b001));
    cycle();
    chk("err_hold", DW'(s_err), DW'(3'b001));
    in_bsel[1] = 4'b0011;
    in_esel[1] = 8'b0000_0001;
    in_pop[1]  = 1'b1;
    cycle();
    idle();
    cycle();
    chk("err_not_onehot", DW'(s_err), DW'(3'b011));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("err_rst", DW'(s_err), DW'(3'b000));
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < NB; b++) begin
        in_valid[b] = ($urandom_range(0, 9) < 6);
        in_data[b]  = {$urandom, $urandom, $urandom, $urandom};
        in_chid[b]  = ($urandom_range(0, 15) == 0) ? 2'd3 : CW'($urandom_range(0, NC - 1));
      end
      for (int c = 0; c < NC; c++) begin
        pick_sel(c);
        in_pop[c] = ($urandom_range(0, 9) < 4);
      end
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
